store_commit_unit: RTL

Drains architecturally committed stores from the store queue to data memory in program order. It owns the store-queue head pointer, counts stores the ROB has retired but not yet written, and issues one aligned word write per store over a valid/ready request and response handshake. After each write is acknowledged it pulses `stq_commit` with `stq_commit_index` for one cycle. That pulse feeds the LSU order-failure search, and the same pulse frees the head entry.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/store_lane_aligner.sv | 46 ++++
 rtl/store_commit_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store unit types: commit FSM states, store width encodings, memory write payload.
// Pure definitions; carries no latency or flow control of its own.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    COMMIT    = 2'd3
  } commit_state_t;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  localparam int WORD_W = 32;

  typedef struct packed {
    logic [WORD_W-1:0]   address;
    logic [WORD_W-1:0]   data;
    logic [WORD_W/8-1:0] byte_enable;
  } mem_wr_t;

  // True when the width is a known store size and the address is naturally aligned for it.
  function automatic logic store_is_legal(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      SB:      return 1'b1;
      SH:      return !lane[0];
      SW:      return lane == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_aligner.sv
// Places a right-justified store onto its byte lanes of an aligned word and builds the strobes.
// Purely combinational, zero latency, no flow control.
module store_lane_aligner
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   address,
  input  logic [XLEN-1:0]   data,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   aligned_address,
  output logic [XLEN-1:0]   aligned_data,
  output logic [XLEN/8-1:0] byte_enable
);

  localparam int BW = XLEN / 8;

  logic [1:0] lane;
  logic [4:0] bit_shift;

  assign lane            = address[1:0];
  assign bit_shift       = {lane, 3'b000};
  assign aligned_address = {address[XLEN-1:2], 2'b00};

  // Unknown widths produce no strobes so a bad entry can never corrupt memory.
  always_comb begin
    aligned_data = '0;
    byte_enable  = '0;
    case (funct3)
      SB: begin
        byte_enable  = BW'(1) << lane;
        aligned_data = XLEN'(data[7:0]) << bit_shift;
      end
      SH: begin
        byte_enable  = BW'(3) << lane;
        aligned_data = XLEN'(data[15:0]) << bit_shift;
      end
      SW: begin
        byte_enable  = '1;
        aligned_data = data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_commit_unit.sv
// Drains retired stores from the store queue head to memory in program order, one word write each.
// Four cycles minimum per store; stalls in REQ on mem_req_ready low and in WAIT_RESP until acknowledged.
module store_commit_unit
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int STQ_SIZE = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rob_commit_store,
  input  logic [STQ_SIZE-1:0]              stq_valid,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]    stq_address,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]    stq_data,
  input  logic [STQ_SIZE-1:0][2:0]         stq_funct3,
  output logic [$clog2(STQ_SIZE)-1:0]      stq_head,
  output logic [$clog2(STQ_SIZE):0]        pending_count,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic [XLEN-1:0]                  mem_req_address,
  output logic [XLEN-1:0]                  mem_req_data,
  output logic [XLEN/8-1:0]                mem_req_byte_enable,
  input  logic                             mem_resp_valid,
  output logic                             stq_commit,
  output logic [$clog2(STQ_SIZE)-1:0]      stq_commit_index,
  output logic                             stq_free
);

  localparam int IW = $clog2(STQ_SIZE);
  localparam int CW = IW + 1;

  commit_state_t state_q, state_d;
  logic [IW-1:0] head_q;
  logic [CW-1:0] pend_q;
  mem_wr_t       req_q;
  mem_wr_t       head_wr;
  logic          start;
  logic          inc;
  logic          dec;

  logic [2:0]        head_funct3;
  logic [XLEN-1:0]   al_address;
  logic [XLEN-1:0]   al_data;
  logic [XLEN/8-1:0] al_byte_enable;

  assign head_funct3 = stq_funct3[head_q];

  store_lane_aligner #(.XLEN(XLEN)) u_aligner (
    .address         (stq_address[head_q]),
    .data            (stq_data[head_q]),
    .funct3          (head_funct3),
    .aligned_address (al_address),
    .aligned_data    (al_data),
    .byte_enable     (al_byte_enable)
  );

  assign head_wr = '{address: al_address, data: al_data, byte_enable: al_byte_enable};

  // Outputs depend on state_q only, keeping every output registered-path.
  always_comb begin
    state_d       = state_q;
    start         = 1'b0;
    mem_req_valid = 1'b0;
    stq_commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0 && stq_valid[head_q]) begin
          start   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (mem_resp_valid) state_d = COMMIT;
      end
      COMMIT: begin
        stq_commit = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign inc = rob_commit_store && (pend_q != CW'(STQ_SIZE));
  assign dec = (state_q == COMMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      pend_q  <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) req_q <= head_wr;
      if (dec) head_q <= head_q + IW'(1);
      case ({inc, dec})
        2'b10:   pend_q <= pend_q + CW'(1);
        2'b01:   pend_q <= pend_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign stq_head            = head_q;
  assign pending_count       = pend_q;
  assign stq_commit_index    = head_q;
  assign stq_free            = stq_commit;
  assign mem_req_address     = req_q.address;
  assign mem_req_data        = req_q.data;
  assign mem_req_byte_enable = req_q.byte_enable;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(rob_commit_store && pend_q == CW'(STQ_SIZE)));

  a_head_valid: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE && pend_q != '0) |-> stq_valid[head_q]);

  a_legal_store: assert property (@(posedge clk) disable iff (reset)
    start |-> store_is_legal(head_funct3, stq_address[head_q][1:0]));

endmodule
